// File: rtl/cheat_pgm_sequencer_pkg.sv
// Shared encodings for the cheat-table programming sequencer: programming
// indices, FSM states and the bit layout of the flag word.
package cheat_pgm_sequencer_pkg;

  localparam int NUM_SLOTS    = 6;
  localparam int NUM_ENTRIES  = 8;
  localparam int IDLE_TIMEOUT = 1023;
  localparam int IDX_W        = 3;
  localparam int DATA_W       = 32;
  localparam int IDLE_CNT_W   = 10;

  localparam logic [IDX_W-1:0] IDX_MASK  = 3'd6;
  localparam logic [IDX_W-1:0] IDX_FLAGS = 3'd7;

  // Flag word: set bits live in [5:0], the matching clear bits in [13:8].
  localparam int FLAG_CHEAT        = 0;
  localparam int FLAG_NMI          = 1;
  localparam int FLAG_IRQ          = 2;
  localparam int FLAG_HOLDOFF      = 3;
  localparam int FLAG_BUTTONS      = 4;
  localparam int FLAG_WRAM_PRESENT = 5;
  localparam int FLAG_CLR_LSB      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_SLOTS   = 3'd2,
    ST_MASK    = 3'd3,
    ST_FLAGS   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic is_slot(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NUM_SLOTS);
  endfunction

endpackage

// File: rtl/cheat_pgm_sequencer_if.sv
// MCU shadow-write port and cheat-engine programming port of the sequencer.
interface cheat_pgm_sequencer_if;
  import cheat_pgm_sequencer_pkg::*;

  // mcu_we/mcu_commit are one-clk strobes whose implicit ready is !busy: a
  // write offered while busy is dropped (and flagged), a commit is remembered.
  // pgm_we is a one-clk valid with no ready; the engine always takes the word.
  logic              mcu_we;
  logic [IDX_W-1:0]  mcu_idx;
  logic [DATA_W-1:0] mcu_wdata;
  logic              mcu_commit;
  logic [IDX_W-1:0]  pgm_idx;
  logic              pgm_we;
  logic [DATA_W-1:0] pgm_in;

  modport master (
    output mcu_we, mcu_idx, mcu_wdata, mcu_commit,
    input  pgm_idx, pgm_we, pgm_in
  );

  modport slave (
    input  mcu_we, mcu_idx, mcu_wdata, mcu_commit,
    output pgm_idx, pgm_we, pgm_in
  );

endinterface

// File: rtl/cheat_pgm_sequencer_grant.sv
// Write-slot grant: one slot per SNES bus cycle, placed a clk after the cycle
// start, or continuously once the SNES has gone quiet; never during a hook.
module cheat_pgm_grant
  import cheat_pgm_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic SNES_cycle_start,
  input  logic snescmd_unlock,
  output logic grant
);

  logic                  r_cs_d;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic                  w_stalled;

  assign w_stalled = (r_idle_cnt == IDLE_CNT_W'(IDLE_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_d     <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_cs_d <= SNES_cycle_start;
      if (SNES_cycle_start) begin
        r_idle_cnt <= '0;
      end else if (!w_stalled) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign grant = ~snescmd_unlock & (r_cs_d | w_stalled);

endmodule

// File: rtl/cheat_pgm_sequencer.sv
// Cheat-table programming sequencer: shadows MCU updates and replays them into
// the cheat engine one word per granted SNES bus cycle.
module cheat_pgm_sequencer
  import cheat_pgm_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cheat_pgm_sequencer_if.slave bus,
  input  logic                 SNES_cycle_start,
  input  logic                 snescmd_unlock,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output state_t               dbg_state
);

  logic              w_grant;
  logic              w_busy;
  logic              w_wr_ok;
  logic              w_slot_dirty;
  logic              w_last_slot;

  state_t            r_state;
  logic [DATA_W-1:0] r_shadow [NUM_ENTRIES];
  logic [NUM_SLOTS-1:0] r_dirty;
  logic [IDX_W-1:0]  r_slot;
  logic              r_pending;
  logic              r_overrun;
  logic              r_done;
  logic              r_pgm_we;
  logic [IDX_W-1:0]  r_pgm_idx;
  logic [DATA_W-1:0] r_pgm_in;

  cheat_pgm_grant u_grant (
    .clk              (clk),
    .rst              (rst),
    .SNES_cycle_start (SNES_cycle_start),
    .snescmd_unlock   (snescmd_unlock),
    .grant            (w_grant)
  );

  assign w_busy       = (r_state != ST_IDLE) | r_pending;
  assign w_wr_ok      = bus.mcu_we & ~w_busy;
  assign w_slot_dirty = r_dirty[r_slot];
  assign w_last_slot  = (r_slot == IDX_W'(NUM_SLOTS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_dirty   <= '0;
      r_slot    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_done    <= 1'b0;
      r_pgm_we  <= 1'b0;
      r_pgm_idx <= '0;
      r_pgm_in  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_pgm_we <= 1'b0;
      r_done   <= 1'b0;

      // Shadow writes are only taken in IDLE, so they never race the scan below.
      if (w_wr_ok) begin
        r_shadow[bus.mcu_idx] <= bus.mcu_wdata;
        if (is_slot(bus.mcu_idx)) begin
          r_dirty[bus.mcu_idx] <= 1'b1;
        end
      end
      if (bus.mcu_we && w_busy) begin
        r_overrun <= 1'b1;
      end
      if (bus.mcu_commit && w_busy) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.mcu_commit) begin
            r_overrun <= 1'b0;
            r_state   <= ST_QUIESCE;
          end
        end
        ST_QUIESCE: begin
          if (w_grant) begin
            r_pgm_we  <= 1'b1;
            r_pgm_idx <= IDX_MASK;
            r_pgm_in  <= '0;
            r_slot    <= '0;
            r_state   <= ST_SLOTS;
          end
        end
        ST_SLOTS: begin
          // Clean slots fall through in one clk; dirty ones wait for a grant.
          if (!w_slot_dirty || w_grant) begin
            if (w_slot_dirty) begin
              r_pgm_we        <= 1'b1;
              r_pgm_idx       <= r_slot;
              r_pgm_in        <= r_shadow[r_slot];
              r_dirty[r_slot] <= 1'b0;
            end
            if (w_last_slot) begin
              r_state <= ST_MASK;
            end else begin
              r_slot <= r_slot + 1'b1;
            end
          end
        end
        ST_MASK: begin
          if (w_grant) begin
            r_pgm_we  <= 1'b1;
            r_pgm_idx <= IDX_MASK;
            r_pgm_in  <= r_shadow[IDX_MASK];
            r_state   <= ST_FLAGS;
          end
        end
        ST_FLAGS: begin
          if (w_grant) begin
            r_pgm_we  <= 1'b1;
            r_pgm_idx <= IDX_FLAGS;
            r_pgm_in  <= r_shadow[IDX_FLAGS];
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
          if (r_pending || bus.mcu_commit) begin
            r_pending <= 1'b0;
            r_state   <= ST_QUIESCE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pgm_we  = r_pgm_we;
  assign bus.pgm_idx = r_pgm_idx;
  assign bus.pgm_in  = r_pgm_in;
  assign busy        = w_busy;
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cheat_pgm_sequencer.sv
// Bench for cheat_pgm_sequencer: directed scenarios plus randomized commits,
// checked against a word-level scoreboard of the expected programming writes.
module tb_cheat_pgm_sequencer;
  import cheat_pgm_sequencer_pkg::*;

  localparam int W = 35;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   SNES_cycle_start = 1'b0;
  logic   snescmd_unlock = 1'b0;
  logic   busy, done, overrun;
  state_t dbg_state;

  cheat_pgm_sequencer_if bus ();

  cheat_pgm_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .SNES_cycle_start (SNES_cycle_start),
    .snescmd_unlock   (snescmd_unlock),
    .busy             (busy),
    .done             (done),
    .overrun          (overrun),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and reference model state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] m_shadow [8];
  logic [5:0]  m_dirty;
  bit          m_busy, m_pend, m_overrun;

  int cyc = 0, we_cnt = 0, done_cnt = 0, last_we_cyc = 0;
  bit cs_h1, cs_h2, unl_h1, prev_flags;
  int cs_q[$];
  int cs_mode = 1, cs_per = 8, unl_mode = 0;
  bit stall_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) m_shadow[i] = '0;
    m_dirty = '0; m_busy = 0; m_pend = 0; m_overrun = 0;
  endfunction

  // One commit: disable all patches, every dirty slot in order, mask, flags.
  function automatic void push_seq();
    exp_q.push_back({3'd6, 32'd0});
    for (int i = 0; i < 6; i++) begin
      if (m_dirty[i]) begin
        exp_q.push_back({3'(i), m_shadow[i]});
        m_dirty[i] = 1'b0;
      end
    end
    exp_q.push_back({3'd6, m_shadow[6]});
    exp_q.push_back({3'd7, m_shadow[7]});
  endfunction

  function automatic void model_apply(input logic we, input logic [2:0] idx,
                                      input logic [31:0] d, input logic commit);
    if (we) begin
      if (!m_busy) begin
        m_shadow[idx] = d;
        if (idx < 3'd6) m_dirty[idx] = 1'b1;
      end else begin
        m_overrun = 1;
      end
    end
    if (commit) begin
      if (!m_busy) begin
        m_busy = 1; m_overrun = 0; push_seq();
      end else begin
        m_pend = 1;
      end
    end
  endfunction

  task automatic monitor();
    logic [W-1:0] e;
    if (bus.pgm_we === 1'b1) begin
      chk("we_unlock_low", unl_h1, 0);
      if (!stall_mode) chk("we_after_cs_d", cs_h2, 1);
      if (exp_q.size() == 0) begin
        chk("we_unexpected", bus.pgm_we, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pgm_word", {bus.pgm_idx, bus.pgm_in}, e);
      end
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (done === 1'b1 || prev_flags) chk("done_after_flags", done, prev_flags);
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_q_empty", exp_q.size(), 0);
      chk("done_expected", done, m_busy);
      if (m_pend) begin
        m_pend = 0; push_seq();
      end else begin
        m_busy = 0;
      end
    end
    prev_flags = (bus.pgm_we === 1'b1) && (bus.pgm_idx == 3'd7);
    cs_h2  = cs_h1;
    cs_h1  = SNES_cycle_start;
    unl_h1 = snescmd_unlock;
    if (SNES_cycle_start) cs_q.push_back(cyc);
  endtask

  // driver: one clk of MCU inputs, background SNES activity, then sampling
  task automatic step(input logic we, input logic [2:0] idx, input logic [31:0] d,
                      input logic commit);
    @(posedge clk);
    cyc++;
    #1;
    bus.mcu_we     = we;
    bus.mcu_idx    = idx;
    bus.mcu_wdata  = d;
    bus.mcu_commit = commit;
    if (!rst) model_apply(we, idx, d, commit);
    case (cs_mode)
      1:       SNES_cycle_start = ((cyc % cs_per) == 0);
      2:       SNES_cycle_start = ($urandom_range(0, 3) == 0);
      default: SNES_cycle_start = 1'b0;
    endcase
    case (unl_mode)
      1:       snescmd_unlock = 1'b1;
      2:       if ($urandom_range(0, 7) == 0) snescmd_unlock = ~snescmd_unlock;
      default: snescmd_unlock = 1'b0;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic step_idle();
    step(1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_we(input int target, input int budget);
    int n = 0;
    while (we_cnt < target && n < budget) begin step_idle(); n++; end
    chk("wait_we", we_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin step_idle(); n++; end
    chk("seq_complete", m_busy, 0);
    repeat (2) step_idle();
    chk("busy_low", busy, 0);
    chk("q_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base, rel, ncs, nw;
    bus.mcu_we = 0; bus.mcu_idx = 0; bus.mcu_wdata = 0; bus.mcu_commit = 0;
    model_reset();

    // reset state
    repeat (3) step_idle();
    chk("rst_pgm_we", bus.pgm_we, 0);
    chk("rst_pgm_idx", bus.pgm_idx, 0);
    chk("rst_pgm_in", bus.pgm_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 0;
    repeat (4) step_idle();

    // directed: one dirty slot, SNES cycle every 8 clk
    base = we_cnt;
    step(1, 3'd2, 32'h00FFEA5C, 0);
    step(1, 3'd6, 32'h4, 0);
    step(1, 3'd7, 32'h1, 0);
    step(0, 3'd0, 32'd0, 1);
    chk("busy_at_commit", busy, 0);
    step_idle();
    chk("busy_after_commit", busy, 1);
    wait_idle(300);
    chk("t1_words", we_cnt - base, 4);

    // hook active for 40 clk right after the quiesce write
    cs_q.delete();
    base = we_cnt;
    step(1, 3'd2, $urandom, 0);
    step(0, 3'd0, 32'd0, 1);
    wait_we(base + 1, 300);
    unl_mode = 1;
    repeat (40) step_idle();
    chk("no_we_while_unlock", we_cnt, base + 1);
    unl_mode = 0;
    step_idle();
    rel = cyc;
    wait_we(base + 2, 300);
    ncs = 0;
    foreach (cs_q[i]) if (cs_q[i] >= rel - 1 && cs_q[i] <= last_we_cyc - 2) ncs++;
    chk("slot_on_first_cs_d", ncs, 1);
    wait_idle(300);

    // SNES stopped: grant saturates, writes go back-to-back
    cs_mode = 0; stall_mode = 1;
    repeat (1030) step_idle();
    step(1, 3'd1, $urandom, 0);
    step(1, 3'd3, $urandom, 0);
    step(1, 3'd5, $urandom, 0);
    base = we_cnt;
    step(0, 3'd0, 32'd0, 1);
    wait_we(base + 1, 50);
    rel = last_we_cyc;
    wait_idle(100);
    chk("stall_pulses", we_cnt - base, 6);
    chk("stall_span", last_we_cyc - rel, 8);
    cs_mode = 1;
    repeat (20) step_idle();
    stall_mode = 0;

    // commits and a write while busy: overrun, one extra sequence
    base = done_cnt;
    step(1, 3'd4, $urandom, 0);
    step(0, 3'd0, 32'd0, 1);
    repeat (3) step_idle();
    step(0, 3'd0, 32'd0, 1);
    step(1, 3'd0, $urandom, 0);
    step(0, 3'd0, 32'd0, 1);
    chk("overrun_set", overrun, m_overrun);
    wait_idle(500);
    chk("extra_seq_dones", done_cnt - base, 2);
    chk("overrun_sticky", overrun, m_overrun);
    step(0, 3'd0, 32'd0, 1);
    step_idle();
    chk("overrun_cleared", overrun, m_overrun);
    wait_idle(300);

    // reset between slot 0 and slot 3 writes
    step(1, 3'd0, $urandom, 0);
    step(1, 3'd3, $urandom, 0);
    step(1, 3'd5, $urandom, 0);
    base = we_cnt;
    step(0, 3'd0, 32'd0, 1);
    wait_we(base + 2, 300);
    rst = 1;
    step_idle();
    rst = 0;
    model_reset();
    step_idle();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    repeat (30) step_idle();
    chk("no_we_after_rst", we_cnt, base + 2);
    base = we_cnt;
    step(0, 3'd0, 32'd0, 1);
    wait_idle(300);
    chk("post_rst_words", we_cnt - base, 3);

    // write and commit in the same clk
    step(1, 3'd5, $urandom, 1);
    wait_idle(300);

    // randomized commits against the model
    for (int it = 0; it < 12; it++) begin
      cs_mode  = (it % 2 == 0) ? 1 : 2;
      cs_per   = $urandom_range(2, 9);
      unl_mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) step(1, 3'($urandom_range(0, 7)), $urandom, 0);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 1);
      repeat (3) step_idle();
      if ($urandom_range(0, 1) == 1)
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 1);
      wait_idle(4000);
      unl_mode = 0;
      step_idle();
      chk("rand_overrun", overrun, m_overrun);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
